// File: rtl/rv32i_types.sv
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared types for the store buffer: the FIFO entry layout and
//               the drain FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    // One committed store: word address plus lane-aligned mask/data.
    typedef struct packed {
        logic        valid;
        logic [29:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } sb_entry_t;

    typedef enum logic [0:0] {
        SB_IDLE  = 1'b0,
        SB_WRITE = 1'b1
    } sb_state_t;

endpackage

`default_nettype wire

// File: rtl/store_buffer_fwd.sv
// ============================================================================
// Module      : store_buffer_fwd
// Description : Combinational store-to-load forwarding. For every byte lane
//               the youngest valid entry matching the load word address and
//               writing that lane supplies the byte.
// Ports       : entries     - store buffer entry array
//               head        - index of the oldest entry
//               count       - number of occupied entries
//               ld_addr     - load byte address
//               ld_fwd_mask - lanes supplied by the buffer
//               ld_fwd_data - forwarded bytes, zero outside the mask
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer_fwd
    import rv32i_types::*;
#(
    parameter int SB_DEPTH = 2
) (
    input  sb_entry_t             entries [2**SB_DEPTH],
    input  logic [SB_DEPTH-1:0]   head,
    input  logic [SB_DEPTH:0]     count,
    input  logic [31:0]           ld_addr,
    output logic [3:0]            ld_fwd_mask,
    output logic [31:0]           ld_fwd_data
);

    localparam int C_NUM_ELEM = 2**SB_DEPTH;

    // Byte offset is irrelevant: forwarding is decided per lane of the word.
    logic w_unused_ld_lsb;
    assign w_unused_ld_lsb = &{1'b0, ld_addr[1:0]};

    logic [SB_DEPTH-1:0] w_idx;
    sb_entry_t           w_ent;

    // Walk oldest to youngest; a later (younger) match overwrites an earlier
    // one, which gives youngest-first priority. Indexing is relative to head
    // and wraps in SB_DEPTH bits, so a tail numerically below head is handled.
    always_comb begin
        ld_fwd_mask = '0;
        ld_fwd_data = '0;
        w_idx       = '0;
        w_ent       = '0;
        for (int k = 0; k < C_NUM_ELEM; k++) begin
            w_idx = head + SB_DEPTH'(k);
            w_ent = entries[w_idx];
            if (((SB_DEPTH+1)'(k) < count) && w_ent.valid && (w_ent.addr == ld_addr[31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_ent.wmask[b]) begin
                        ld_fwd_mask[b]       = 1'b1;
                        ld_fwd_data[8*b +: 8] = w_ent.wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// Module      : store_buffer
// Description : In-order queue of committed stores. Drains one store at a
//               time through an arbitrated dmem write port and forwards
//               pending bytes to the load unit.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               push_*              - committed store from the store RS
//               store_buffer_full   - back-pressure to the store RS pop
//               store_buffer_empty  - no pending stores
//               dmem_req/gnt/resp   - arbitrated write port handshake
//               dmem_addr/wmask/wdata - write command, valid in WRITE only
//               ld_addr, ld_fwd_*   - load forwarding lookup
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer
    import rv32i_types::*;
#(
    parameter int SB_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_valid,
    input  logic [31:0] push_addr,
    input  logic [3:0]  push_wmask,
    input  logic [31:0] push_wdata,
    output logic        store_buffer_full,
    output logic        store_buffer_empty,
    output logic        dmem_req,
    input  logic        dmem_gnt,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_resp,
    input  logic [31:0] ld_addr,
    output logic [3:0]  ld_fwd_mask,
    output logic [31:0] ld_fwd_data
);

    localparam int                C_NUM_ELEM   = 2**SB_DEPTH;
    localparam logic [SB_DEPTH:0] C_FULL_COUNT = (SB_DEPTH+1)'(C_NUM_ELEM);

    sb_entry_t           r_entries [C_NUM_ELEM];
    logic [SB_DEPTH-1:0] r_head;
    logic [SB_DEPTH-1:0] r_tail;
    logic [SB_DEPTH:0]   r_count;
    sb_state_t           r_state;
    sb_state_t           w_state_next;
    logic                w_push;
    logic                w_pop;
    sb_entry_t           w_head_ent;

    // Store byte offset is already folded into push_wmask.
    logic w_unused_push_lsb;
    assign w_unused_push_lsb = &{1'b0, push_addr[1:0]};

    assign store_buffer_full  = (r_count == C_FULL_COUNT);
    assign store_buffer_empty = (r_count == '0);
    assign w_push             = push_valid && !store_buffer_full;
    assign w_head_ent         = r_entries[r_head];

    // Storage and pointers. A push never targets the head slot while a write
    // is in flight (count >= 1 and not full), so the drained entry is stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_NUM_ELEM; i++) begin
                r_entries[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + 1'b1;
            end
            if (w_push) begin
                r_entries[r_tail] <= '{valid: 1'b1,
                                       addr:  push_addr[31:2],
                                       wmask: push_wmask,
                                       wdata: push_wdata};
                r_tail            <= r_tail + 1'b1;
            end
            r_count <= r_count + (SB_DEPTH+1)'(w_push) - (SB_DEPTH+1)'(w_pop);
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Drain FSM next state and dmem port outputs.
    always_comb begin
        w_state_next = r_state;
        dmem_req     = 1'b0;
        dmem_addr    = '0;
        dmem_wmask   = '0;
        dmem_wdata   = '0;
        w_pop        = 1'b0;
        case (r_state)
            SB_IDLE: begin
                dmem_req = !store_buffer_empty;
                if (!store_buffer_empty && dmem_gnt) begin
                    w_state_next = SB_WRITE;
                end
            end
            SB_WRITE: begin
                dmem_addr  = {w_head_ent.addr, 2'b00};
                dmem_wmask = w_head_ent.wmask;
                dmem_wdata = w_head_ent.wdata;
                if (dmem_resp) begin
                    w_pop        = 1'b1;
                    w_state_next = SB_IDLE;
                end
            end
            default: begin
                w_state_next = SB_IDLE;
            end
        endcase
    end

    // The producer must never pop the store RS while the buffer is full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push_valid && store_buffer_full))
                else $warning("store_buffer: push while full dropped");
        end
    end

    store_buffer_fwd #(
        .SB_DEPTH (SB_DEPTH)
    ) u_fwd (
        .entries     (r_entries),
        .head        (r_head),
        .count       (r_count),
        .ld_addr     (ld_addr),
        .ld_fwd_mask (ld_fwd_mask),
        .ld_fwd_data (ld_fwd_data)
    );

endmodule

`default_nettype wire
